tact_debounce: RTL

- Input-side companion to the LED sequencer: turns the raw, bouncing, active-low Tact1 push-button into clean, synchronous, single-cycle press events.
- Synchronises the input, debounces it with a stability counter, then classifies each press as short or long.
- Instantiated at the top level between the Tact1 pin and any consumer logic; runs entirely on CLK_24MHz.

---
 rtl/tact_pkg.sv | 13 +
 rtl/sync2.sv | 23 ++
 rtl/tact_debounce.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/tact_pkg.sv
// Shared constants for the Tact1 button path: pin polarity and classification FSM encodings.
package tact_pkg;

  localparam logic TACT_ON  = 1'b0;
  localparam logic TACT_OFF = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'h0,
    ST_HELD = 2'h1,
    ST_LONG = 2'h2
  } tact_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous pin inputs; RST_VAL is the level both flops reset to.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic CLK_24MHz,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge CLK_24MHz) begin
    if (RST) begin
      s1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/tact_debounce.sv
// Tact1 button front end: synchronise, debounce, then classify each press as short or long.
// Define TACT_REPEAT_EN to make LONG_PULSE auto-repeat every REPEAT_CYCLES while held.
module tact_debounce
  import tact_pkg::*;
#(
  parameter int DB_CYCLES     = 120000,
  parameter int LONG_CYCLES   = 24000000,
  parameter int REPEAT_CYCLES = 4800000
) (
  input  logic CLK_24MHz,
  input  logic RST,
  input  logic TACT_IN,
  output logic PRESSED,
  output logic PRESS_PULSE,
  output logic RELEASE_PULSE,
  output logic SHORT_PULSE,
  output logic LONG_PULSE
);

  localparam int DB_W   = $clog2(DB_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES);
`ifdef TACT_REPEAT_EN
  localparam int REP_W  = $clog2(REPEAT_CYCLES);
`endif

  logic              s2;
  logic              stable;
  logic [DB_W-1:0]   db_cnt;
  logic              press_evt;
  logic              release_evt;
  tact_state_t       state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              short_nxt;
  logic              long_nxt;
`ifdef TACT_REPEAT_EN
  logic [REP_W-1:0]  rep_cnt, rep_nxt;
`endif

  sync2 #(.RST_VAL(TACT_OFF)) u_sync (
    .CLK_24MHz(CLK_24MHz),
    .RST      (RST),
    .d        (TACT_IN),
    .q        (s2)
  );

  // Stable level only follows s2 after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge CLK_24MHz) begin
    if (RST) begin
      stable <= TACT_OFF;
      db_cnt <= '0;
    end else if (s2 == stable) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
      stable <= s2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign press_evt   = (stable == TACT_ON)  && !PRESSED;
  assign release_evt = (stable == TACT_OFF) &&  PRESSED;

  always_ff @(posedge CLK_24MHz) begin
    if (RST) begin
      state         <= ST_IDLE;
      hold_cnt      <= '0;
      PRESSED       <= 1'b0;
      PRESS_PULSE   <= 1'b0;
      RELEASE_PULSE <= 1'b0;
      SHORT_PULSE   <= 1'b0;
      LONG_PULSE    <= 1'b0;
`ifdef TACT_REPEAT_EN
      rep_cnt       <= '0;
`endif
    end else begin
      state         <= state_nxt;
      hold_cnt      <= hold_nxt;
      PRESSED       <= (stable == TACT_ON);
      PRESS_PULSE   <= press_evt;
      RELEASE_PULSE <= release_evt;
      SHORT_PULSE   <= short_nxt;
      LONG_PULSE    <= long_nxt;
`ifdef TACT_REPEAT_EN
      rep_cnt       <= rep_nxt;
`endif
    end
  end

  // Release is tested before the long threshold so a coincident release classifies as short.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    short_nxt = 1'b0;
    long_nxt  = 1'b0;
`ifdef TACT_REPEAT_EN
    rep_nxt   = rep_cnt;
`endif
    case (state)
      ST_IDLE: begin
        if (press_evt) begin
          state_nxt = ST_HELD;
          hold_nxt  = '0;
        end
      end
      ST_HELD: begin
        if (release_evt) begin
          state_nxt = ST_IDLE;
          short_nxt = 1'b1;
        end else if (hold_cnt == HOLD_W'(LONG_CYCLES - 1)) begin
          state_nxt = ST_LONG;
          long_nxt  = 1'b1;
`ifdef TACT_REPEAT_EN
          rep_nxt   = '0;
`endif
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      ST_LONG: begin
        if (release_evt) begin
          state_nxt = ST_IDLE;
`ifdef TACT_REPEAT_EN
          rep_nxt   = '0;
`endif
        end
`ifdef TACT_REPEAT_EN
        else if (rep_cnt == REP_W'(REPEAT_CYCLES - 1)) begin
          long_nxt = 1'b1;
          rep_nxt  = '0;
        end else begin
          rep_nxt = rep_cnt + 1'b1;
        end
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
